// File: rtl/hc_sync_fifo.sv
// hc_sync_fifo: synchronous FIFO with registered-count flags, sticky errors and
// selectable first-word-fall-through or registered read port.
module hc_sync_fifo #(
    parameter int WIDTH         = 512,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int SHOWAHEAD     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       enq_en,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       deq_en,
    output logic [WIDTH-1:0]           deq_data,
    output logic                       deq_valid,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     free,
    input  logic                       err_clr,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    // Flags come only from the registered count, so enq_en/deq_en never reach them.
    assign full         = count == DEPTH_C;
    assign empty        = count == '0;
    assign almost_full  = count >= AF_C;
    assign almost_empty = count <= AE_C;
    assign free         = DEPTH_C - count;

    assign wr = enq_en && !full && !flush;
    assign rd = deq_en && !empty && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= flush ? '0 : wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= flush ? '0 : rd ? rd_ptr + 1'b1 : rd_ptr;
            count     <= flush ? '0 : (wr && !rd) ? count + 1'b1 : (rd && !wr) ? count - 1'b1 : count;
            overflow  <= (enq_en && full && !flush) || (overflow && !err_clr);
            underflow <= (deq_en && empty && !flush) || (underflow && !err_clr);
        end
    end

    // Storage is deliberately unreset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= enq_data;
    end

    generate
        if (SHOWAHEAD != 0) begin : g_fwft
            assign deq_data  = mem[rd_ptr];
            assign deq_valid = !empty;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_q;
            logic             v_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_q <= '0;
                    v_q  <= 1'b0;
                end else begin
                    v_q <= rd;
                    if (rd) rd_q <= mem[rd_ptr];
                end
            end
            assign deq_data  = rd_q;
            assign deq_valid = v_q;
        end
    endgenerate
endmodule

// File: tb/tb_hc_sync_fifo.sv
// tb_hc_sync_fifo: directed checks of hc_sync_fifo in both read modes.
module tb_hc_sync_fifo;
    localparam int W = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic [W-1:0] enq_data = '0;
    logic enq_en = 1'b0;
    logic deq_en = 1'b0;
    logic err_clr = 1'b0;

    logic full, almost_full, deq_valid, empty, almost_empty, overflow, underflow;
    logic [W-1:0] deq_data;
    logic [3:0] count, free;
    logic full2, almost_full2, deq_valid2, empty2, almost_empty2, overflow2, underflow2;
    logic [W-1:0] deq_data2;
    logic [3:0] count2, free2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hc_sync_fifo dut (
        .clk(clk), .reset(reset), .flush(flush), .enq_data(enq_data), .enq_en(enq_en),
        .full(full), .almost_full(almost_full), .deq_en(deq_en), .deq_data(deq_data),
        .deq_valid(deq_valid), .empty(empty), .almost_empty(almost_empty), .count(count),
        .free(free), .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
    );

    hc_sync_fifo #(.SHOWAHEAD(0)) dut_reg (
        .clk(clk), .reset(reset), .flush(flush), .enq_data(enq_data), .enq_en(enq_en),
        .full(full2), .almost_full(almost_full2), .deq_en(deq_en), .deq_data(deq_data2),
        .deq_valid(deq_valid2), .empty(empty2), .almost_empty(almost_empty2), .count(count2),
        .free(free2), .err_clr(err_clr), .overflow(overflow2), .underflow(underflow2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({count, free, empty, full, almost_empty, almost_full, overflow, underflow, deq_valid}
            !== {4'd0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s flags: count=%0d free=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b v=%b required count=0 free=8 e=1 f=0 ae=1 af=0 ov=0 un=0 v=0",
                     tag, count, free, empty, full, almost_empty, almost_full, overflow, underflow, deq_valid);
        end
        checks++;
        if (deq_valid2 !== 1'b0 || deq_data2 !== '0 || count2 !== 4'd0) begin
            errors++;
            $display("FAIL %s reg_port: valid=%b data=%0h count=%0d required 0 0 0", tag, deq_valid2, deq_data2, count2);
        end
    endtask

    task automatic test_reset();
        #2;
        check_reset_values("reset_async");
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            enq_en = 1'b1;
            enq_data = W'(i);
            step();
            checks++;
            if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 6)) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d af=%b required count=%0d af=%b", i, count, almost_full, i + 1, i + 1 >= 6);
            end
        end
        enq_en = 1'b0;
        checks++;
        if (full !== 1'b1 || free !== 4'd0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b free=%0d empty=%b required 1 0 0", full, free, empty);
        end
    endtask

    task automatic test_overflow_drain();
        enq_en = 1'b1;
        enq_data = W'(99);
        step();
        enq_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL overflow_set: ov=%b count=%0d required 1 8", overflow, count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (deq_data !== W'(i)) begin
                errors++;
                $display("FAIL drain_%0d: data=%0h required %0h", i, deq_data, i);
            end
            deq_en = 1'b1;
            step();
        end
        deq_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: empty=%b count=%0d ov=%b required 1 0 1", empty, count, overflow);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: ov=%b required 0", overflow);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) begin
            enq_en = 1'b1;
            enq_data = W'(10 + i);
            step();
        end
        deq_en = 1'b1;
        err_clr = 1'b1;
        enq_data = W'(50);
        step();
        {enq_en, deq_en, err_clr} = 3'b000;
        checks++;
        if (count !== 4'd7 || overflow !== 1'b1 || deq_data !== W'(11)) begin
            errors++;
            $display("FAIL full_both: count=%0d ov=%b data=%0h required 7 1 b", count, overflow, deq_data);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        {enq_en, deq_en} = 2'b11;
        enq_data = W'(77);
        step();
        {enq_en, deq_en} = 2'b00;
        checks++;
        if (count !== 4'd1 || underflow !== 1'b1 || deq_data !== W'(77)) begin
            errors++;
            $display("FAIL empty_both: count=%0d un=%b data=%0h required 1 1 4d", count, underflow, deq_data);
        end
        flush = 1'b1;
        err_clr = 1'b1;
        step();
        {flush, err_clr} = 2'b00;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            enq_en = 1'b1;
            enq_data = W'(100 + i);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (deq_data !== W'(100 + i)) begin
                errors++;
                $display("FAIL stream_data_%0d: data=%0h required %0h", i, deq_data, 100 + i);
            end
            {enq_en, deq_en} = 2'b11;
            enq_data = W'(103 + i);
            step();
            checks++;
            if (count !== 4'd3) begin
                errors++;
                $display("FAIL stream_count_%0d: count=%0d required 3", i, count);
            end
        end
        {enq_en, deq_en} = 2'b00;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        deq_en = 1'b1;
        step();
        deq_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enq_en = 1'b1;
            enq_data = W'(200 + i);
            step();
        end
        checks++;
        if (count !== 4'd5 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre: count=%0d un=%b required 5 1", count, underflow);
        end
        {flush, deq_en} = 2'b11;
        step();
        {flush, enq_en, deq_en} = 3'b000;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || underflow !== 1'b1 || overflow !== 1'b0 || deq_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL flush: count=%0d empty=%b un=%b ov=%b v2=%b required 0 1 1 0 0", count, empty, underflow, overflow, deq_valid2);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_registered_read();
        enq_en = 1'b1;
        enq_data = W'(8'hA5);
        step();
        enq_en = 1'b0;
        checks++;
        if (deq_valid2 !== 1'b0 || count2 !== 4'd1) begin
            errors++;
            $display("FAIL reg_idle: v=%b count=%0d required 0 1", deq_valid2, count2);
        end
        deq_en = 1'b1;
        step();
        deq_en = 1'b0;
        checks++;
        if (deq_valid2 !== 1'b1 || deq_data2 !== W'(8'hA5)) begin
            errors++;
            $display("FAIL reg_pulse: v=%b data=%0h required 1 a5", deq_valid2, deq_data2);
        end
        step();
        checks++;
        if (deq_valid2 !== 1'b0 || deq_data2 !== W'(8'hA5) || underflow2 !== 1'b0) begin
            errors++;
            $display("FAIL reg_after: v=%b data=%0h un=%b required 0 a5 0", deq_valid2, deq_data2, underflow2);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            enq_en = 1'b1;
            enq_data = W'(300 + i);
            step();
        end
        enq_en = 1'b0;
        deq_en = 1'b1;
        step();
        deq_en = 1'b0;
        enq_en = 1'b1;
        step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("reset_mid");
        enq_en = 1'b0;
        step();
        reset = 1'b0;
        step();
        checks++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: count=%0d empty=%b required 0 1", count, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_simultaneous();
        test_stream();
        test_flush();
        test_registered_read();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
